// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS32 multicycle core: mul/div op codes and FSM states.
package mips_cpu_pkg;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_sign.sv
// Sign handling around the unsigned iterative core: operand magnitudes on
// entry, result sign correction on exit. Purely combinational.
module mips_cpu_muldiv_sign
  import mips_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]              i_op,
  input  logic [DATA_WIDTH-1:0]   i_a,
  input  logic [DATA_WIDTH-1:0]   i_b,
  output logic [DATA_WIDTH-1:0]   o_mag_a,
  output logic [DATA_WIDTH-1:0]   o_mag_b,
  output logic                    o_neg_res,
  output logic                    o_neg_rem,
  input  logic                    i_is_div,
  input  logic                    i_fix_neg_res,
  input  logic                    i_fix_neg_rem,
  input  logic [2*DATA_WIDTH-1:0] i_raw,
  output logic [DATA_WIDTH-1:0]   o_hi,
  output logic [DATA_WIDTH-1:0]   o_lo
);

  logic                    w_signed;
  logic                    w_sa;
  logic                    w_sb;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0]   w_rem;
  logic [DATA_WIDTH-1:0]   w_quo;

  assign w_signed  = (i_op == MULT) || (i_op == DIV);
  assign w_sa      = w_signed & i_a[DATA_WIDTH-1];
  assign w_sb      = w_signed & i_b[DATA_WIDTH-1];
  assign o_mag_a   = w_sa ? -i_a : i_a;
  assign o_mag_b   = w_sb ? -i_b : i_b;
  assign o_neg_res = w_sa ^ w_sb;
  // Remainder follows the dividend sign (truncating division).
  assign o_neg_rem = (i_op == DIV) & w_sa;

  assign w_prod = i_fix_neg_res ? -i_raw : i_raw;
  assign w_quo  = i_fix_neg_res ? -i_raw[DATA_WIDTH-1:0] : i_raw[DATA_WIDTH-1:0];
  assign w_rem  = i_fix_neg_rem ? -i_raw[2*DATA_WIDTH-1:DATA_WIDTH]
                                :  i_raw[2*DATA_WIDTH-1:DATA_WIDTH];

  assign o_hi = i_is_div ? w_rem : w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
  assign o_lo = i_is_div ? w_quo : w_prod[DATA_WIDTH-1:0];

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One shift-add (mult) or restoring-divide step per cycle on unsigned
// magnitudes; signs are reapplied in a single FIX cycle.
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_op_a,
  input  logic [DATA_WIDTH-1:0] i_op_b,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int              CW   = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH);

  muldiv_state_t           r_state;
  logic [CW-1:0]           r_cnt;
  logic [2*DATA_WIDTH-1:0] r_acc;   // mult: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [DATA_WIDTH-1:0]   r_opnd;  // multiplicand or divisor
  logic                    r_is_div;
  logic                    r_neg_res;
  logic                    r_neg_rem;
  logic                    r_div0;
  logic [DATA_WIDTH-1:0]   r_hi;
  logic [DATA_WIDTH-1:0]   r_lo;
  logic                    r_done;

  logic [DATA_WIDTH-1:0]   w_mag_a;
  logic [DATA_WIDTH-1:0]   w_mag_b;
  logic                    w_neg_res;
  logic                    w_neg_rem;
  logic [DATA_WIDTH-1:0]   w_fix_hi;
  logic [DATA_WIDTH-1:0]   w_fix_lo;
  logic                    w_is_div;
  logic                    w_is_md;
  logic [DATA_WIDTH:0]     w_add;
  logic [2*DATA_WIDTH-1:0] w_mul_next;
  logic [DATA_WIDTH:0]     w_shift;
  logic [DATA_WIDTH:0]     w_diff;
  logic [2*DATA_WIDTH-1:0] w_div_next;

  mips_cpu_muldiv_sign #(.DATA_WIDTH(DATA_WIDTH)) u_sign (
    .i_op          (i_op),
    .i_a           (i_op_a),
    .i_b           (i_op_b),
    .o_mag_a       (w_mag_a),
    .o_mag_b       (w_mag_b),
    .o_neg_res     (w_neg_res),
    .o_neg_rem     (w_neg_rem),
    .i_is_div      (r_is_div),
    .i_fix_neg_res (r_neg_res),
    .i_fix_neg_rem (r_neg_rem),
    .i_raw         (r_acc),
    .o_hi          (w_fix_hi),
    .o_lo          (w_fix_lo)
  );

  assign w_is_div = (i_op == DIV) || (i_op == DIVU);
  assign w_is_md  = (i_op == MULT) || (i_op == MULTU) || w_is_div;

  // Shift-add step: conditionally add multiplicand to the upper half, then
  // shift the whole 64-bit accumulator right, carry included.
  assign w_add      = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                    + (r_acc[0] ? {1'b0, r_opnd} : {(DATA_WIDTH+1){1'b0}});
  assign w_mul_next = {w_add, r_acc[DATA_WIDTH-1:1]};

  // Restoring step: shift in the next dividend bit, subtract if it fits.
  // The partial remainder is always below the divisor, so bit DATA_WIDTH of
  // the difference is a clean borrow flag.
  assign w_shift    = {r_acc[2*DATA_WIDTH-1:DATA_WIDTH], r_acc[DATA_WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_opnd};
  assign w_div_next = w_diff[DATA_WIDTH]
                    ? {w_shift[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b0}
                    : {w_diff[DATA_WIDTH-1:0],  r_acc[DATA_WIDTH-2:0], 1'b1};

  // Control FSM plus HI/LO architectural state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start && w_is_md) begin
            r_is_div  <= w_is_div;
            r_neg_res <= w_neg_res;
            r_neg_rem <= w_neg_rem;
            r_div0    <= w_is_div && (w_mag_b == '0);
            r_opnd    <= w_is_div ? w_mag_b : w_mag_a;
            r_acc     <= {{DATA_WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_cnt     <= '0;
            r_state   <= CALC;
          end else if (i_start && (i_op == MTHI)) begin
            r_hi <= i_op_a;
          end else if (i_start && (i_op == MTLO)) begin
            r_lo <= i_op_a;
          end
        end
        CALC: begin
          if (r_cnt == LAST) begin
            r_state <= FIX;
          end else begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FIX: begin
          // Divide by zero leaves HI/LO untouched but still signals completion.
          if (!r_div0) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = (r_state != IDLE);
  assign o_done = r_done;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed vector table, multi-cycle
// corner sequences, and randomized ops checked against an arithmetic model.
module tb_mips_cpu_muldiv;
  import mips_cpu_pkg::*;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;
  logic        o_done;

  mips_cpu_muldiv #(.DATA_WIDTH(32)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .i_op    (i_op),
    .i_op_a  (i_op_a),
    .i_op_b  (i_op_b),
    .o_hi    (o_hi),
    .o_lo    (o_lo),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        vecs[8];
  int          n_chk;
  int          n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the architectural definitions.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; m_hi = r[31:0]; m_lo = q[31:0]; end
      3'd3: if (b != 0) begin up = ua / ub; m_lo = up[31:0]; up = ua % ub; m_hi = up[31:0]; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue a multi-cycle op; returns number of edges after the start edge until done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    logic [31:0] h0, l0;
    bit bad;
    h0 = o_hi; l0 = o_lo; bad = 0; lat = -1;
    i_start = 1'b1; i_op = op; i_op_a = a; i_op_b = b;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_op_a = $urandom; i_op_b = $urandom;
    for (int k = 1; k <= 60; k++) begin
      @(posedge i_clk); #1;
      if (o_done) begin lat = k; break; end
      if (!o_busy || o_hi !== h0 || o_lo !== l0) bad = 1;
    end
    chk("busy_hold", {31'd0, bad}, 32'd0);
    chk("busy_at_done", {31'd0, o_busy}, 32'd0);
  endtask

  // Single-cycle op (MTHI/MTLO/undefined): no busy, no done.
  task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
    i_start = 1'b1; i_op = op; i_op_a = a; i_op_b = $urandom;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("mt_busy", {30'd0, o_busy, o_done}, 32'd0);
  endtask

  initial begin
    int lat;
    int ndone;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    n_chk = 0; n_fail = 0;
    i_reset = 1'b1; i_start = 1'b0; i_op = 3'd0; i_op_a = '0; i_op_b = '0;
    m_hi = '0; m_lo = '0;

    vecs[0] = '{MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4] = '{MTHI,  32'h1234,     32'd0,        32'h1234,     32'd14};
    vecs[5] = '{MTLO,  32'h5678,     32'd0,        32'h1234,     32'h5678};
    vecs[6] = '{DIVU,  32'd9,        32'd0,        32'h1234,     32'h5678};
    vecs[7] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_hi", o_hi, 32'd0);
    chk("rst_lo", o_lo, 32'd0);
    chk("rst_busy_done", {30'd0, o_busy, o_done}, 32'd0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    // Reset mid-CALC aborts the operation
    i_start = 1'b1; i_op = MULTU; i_op_a = 32'd5; i_op_b = 32'd7;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    #1;
    chk("midrst_hi", o_hi, 32'd0);
    chk("midrst_lo", o_lo, 32'd0);
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge i_clk); #1;
      if (o_done || o_busy) ndone++;
    end
    chk("midrst_no_done", ndone, 32'd0);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].op == MTHI || vecs[i].op == MTLO) begin
        run_mt(vecs[i].op, vecs[i].a);
      end else begin
        run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
        chk($sformatf("vec%0d_latency", i), lat, 32'd34);
      end
      chk($sformatf("vec%0d_hi", i), o_hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), o_lo, vecs[i].lo);
    end

    // Busy protection: MTLO and a second DIV issued mid-operation are dropped
    i_start = 1'b1; i_op = DIV; i_op_a = 32'hFFFFFF9C; i_op_b = 32'd7;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge i_clk); #1;
      if (o_done) begin lat = k; break; end
      if (k == 12) chk("busy_lo_hold", o_lo, 32'h80000000);
      i_start = 1'b0;
      if (k == 5) begin i_start = 1'b1; i_op = MTLO; i_op_a = 32'hAAAA; end
      if (k == 8) begin i_start = 1'b1; i_op = DIV; i_op_a = 32'd50; i_op_b = 32'd5; end
    end
    i_start = 1'b0;
    chk("busy_latency", lat, 32'd34);
    chk("busy_hi", o_hi, 32'hFFFFFFFE);
    chk("busy_lo", o_lo, 32'hFFFFFFF2);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge i_clk); #1;
      if (o_done || o_busy) ndone++;
    end
    chk("busy_no_restart", ndone, 32'd0);

    // Back-to-back: MTHI issued while done is visible
    run_op(MULTU, 32'd3, 32'd4, lat);
    chk("b2b_latency", lat, 32'd34);
    run_mt(MTHI, 32'hBEEF);
    chk("b2b_hi", o_hi, 32'hBEEF);
    chk("b2b_lo", o_lo, 32'd12);

    // Randomized ops against the model
    m_hi = o_hi; m_lo = o_lo;
    for (int n = 0; n < 30; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(0, 15));
        1: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      if (rop <= 3'd3) begin
        run_op(rop, ra, rb, lat);
        chk($sformatf("rnd%0d_latency", n), lat, 32'd34);
      end else begin
        run_mt(rop, ra);
      end
      model(rop, ra, rb);
      chk($sformatf("rnd%0d_op%0d_hi", n, rop), o_hi, m_hi);
      chk($sformatf("rnd%0d_op%0d_lo", n, rop), o_lo, m_lo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
